// File: rtl/exception_ctrl.sv
// Exception sequencer: stalls main control, saves EPC, fetches the
// vector byte through the address mux and loads it into PC.
module exception_ctrl #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [31:0] mem_data_in,
    output logic        busy,
    output logic [2:0]  addr_sel,
    output logic [31:0] exc_addr,
    output logic        mem_read,
    output logic        epc_write,
    output logic [2:0]  pc_src_sel,
    output logic [31:0] pc_vector,
    output logic        pc_write,
    output logic [1:0]  cause
);

    typedef enum logic [1:0] {
        IDLE,
        SAVE_EPC,
        WAIT_MEM,
        LOAD_PC
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);
    localparam logic [2:0] SEL_EXC  = 3'b100;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;
    logic [7:0] vec_q, vec_d;

    // Only the low byte of the memory word carries the vector.
    logic unused_mem_hi;
    assign unused_mem_hi = ^mem_data_in[31:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cause_q <= 2'b00;
            vec_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: begin
                if (exc_opcode) begin
                    cause_d = 2'b01;
                    state_d = SAVE_EPC;
                end else if (exc_overflow) begin
                    cause_d = 2'b10;
                    state_d = SAVE_EPC;
                end else if (exc_divzero) begin
                    cause_d = 2'b11;
                    state_d = SAVE_EPC;
                end
            end
            SAVE_EPC: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (cnt_q == 4'd0) begin
                    vec_d   = mem_data_in[7:0];
                    state_d = LOAD_PC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            LOAD_PC: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        addr_sel   = 3'b000;
        mem_read   = 1'b0;
        epc_write  = 1'b0;
        pc_src_sel = 3'b000;
        pc_write   = 1'b0;
        unique case (state_q)
            IDLE: begin
            end
            SAVE_EPC: begin
                busy      = 1'b1;
                epc_write = 1'b1;
                addr_sel  = SEL_EXC;
            end
            WAIT_MEM: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                addr_sel = SEL_EXC;
            end
            LOAD_PC: begin
                busy       = 1'b1;
                pc_write   = 1'b1;
                pc_src_sel = SEL_EXC;
            end
            default: begin
            end
        endcase
    end

    // Vector slots sit at the top of the byte-addressed table: 253..255.
    always_comb begin
        exc_addr = 32'd0;
        unique case (cause_q)
            2'b01:   exc_addr = 32'd253;
            2'b10:   exc_addr = 32'd254;
            2'b11:   exc_addr = 32'd255;
            default: exc_addr = 32'd0;
        endcase
    end

    assign pc_vector = {24'd0, vec_q};
    assign cause     = cause_q;

endmodule
